// File: rtl/sp_ram_be.sv
// Parametrised single-port RAM with byte write enables, selectable read latency and write-collision modes.
// Optional per-lane even parity is compiled in when SP_RAM_BE_PARITY_EN is defined.
module sp_ram_be #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2048,
    parameter int ADDR_WIDTH = 11,
    parameter int READ_MODE  = 0,
    parameter int WRITE_MODE = 0,
    localparam int NB        = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ce,
    input  logic                  oce,
    input  logic                  wre,
    input  logic [NB-1:0]         be,
    input  logic [ADDR_WIDTH-1:0] ad,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_vld,
    output logic                  parity_err
);

    localparam int MW = NB * 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    logic            in_range;
    logic            acc_rd;
    logic            acc_wr;
    logic [IW-1:0]   idx;
    logic [MW-1:0]   din_pad;
    logic [MW-1:0]   old_word;
    logic [MW-1:0]   merged_word;
    logic [NB-1:0]   lane_perr;

    logic [MW-1:0]   s1_reg;
    logic [MW-1:0]   s1_next;
    logic            v1_reg;
    logic            v1_next;
    logic            p1_reg;
    logic            p1_next;

    assign in_range = ({1'b0, ad} < DEPTH_L);
    assign idx      = ad[IW-1:0];
    assign acc_rd   = ce & ~wre;
    assign acc_wr   = ce & wre;

    always_comb begin
        din_pad = '0;
        din_pad[DATA_WIDTH-1:0] = din;
    end

    // One independent 8-bit array per lane so each byte enable maps onto its own write port.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rd;

            always_ff @(posedge clk) begin
                if (reset_n && acc_wr && in_range && be[gi]) begin
                    lane_mem[idx] <= din_pad[gi*8 +: 8];
                end
            end

            assign lane_rd                  = in_range ? lane_mem[idx] : 8'h00;
            assign old_word[gi*8 +: 8]      = lane_rd;
            assign merged_word[gi*8 +: 8]   = be[gi] ? din_pad[gi*8 +: 8] : lane_rd;

`ifdef SP_RAM_BE_PARITY_EN
            logic par_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (reset_n && acc_wr && in_range && be[gi]) begin
                    par_mem[idx] <= ^din_pad[gi*8 +: 8];
                end
            end

            assign lane_perr[gi] = in_range & ((^lane_rd) ^ par_mem[idx]);
`else
            assign lane_perr[gi] = 1'b0;
`endif
        end
    endgenerate

    // Stage 1: what the access produced; write-through data is fresh, so it never flags parity.
    always_comb begin
        s1_next = s1_reg;
        v1_next = 1'b0;
        p1_next = 1'b0;
        if (acc_rd) begin
            s1_next = old_word;
            v1_next = 1'b1;
            p1_next = |lane_perr;
        end else if (acc_wr) begin
            if (WRITE_MODE == 1) begin
                s1_next = merged_word;
                v1_next = 1'b1;
            end else if (WRITE_MODE == 2) begin
                s1_next = old_word;
                v1_next = 1'b1;
                p1_next = |lane_perr;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_reg <= '0;
            v1_reg <= 1'b0;
            p1_reg <= 1'b0;
        end else begin
            s1_reg <= s1_next;
            v1_reg <= v1_next;
            p1_reg <= p1_next;
        end
    end

    generate
        if (READ_MODE == 1) begin : g_pipe
            logic [MW-1:0] s2_reg;
            logic          v2_reg;
            logic          p2_reg;

            // Output register: holds its data while oce is low but never repeats the strobe.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    s2_reg <= '0;
                    v2_reg <= 1'b0;
                    p2_reg <= 1'b0;
                end else if (oce) begin
                    s2_reg <= s1_reg;
                    v2_reg <= v1_reg;
                    p2_reg <= p1_reg;
                end else begin
                    v2_reg <= 1'b0;
                    p2_reg <= 1'b0;
                end
            end

            assign dout       = s2_reg[DATA_WIDTH-1:0];
            assign dout_vld   = v2_reg;
            assign parity_err = p2_reg;
        end else begin : g_bypass
            logic unused_oce;
            assign unused_oce = oce;
            assign dout       = s1_reg[DATA_WIDTH-1:0];
            assign dout_vld   = v1_reg;
            assign parity_err = p1_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sp_ram_be.sv
// Bench for sp_ram_be: four configurations share one stimulus stream and are checked against a word-level model.
// Define SP_RAM_BE_PARITY_EN to add the corrupted-parity scenario.
module tb_sp_ram_be;

    localparam int NI = 4;
    localparam int C_DW    [NI] = '{8, 32, 12, 16};
    localparam int C_DEPTH [NI] = '{2048, 2048, 1000, 2048};
    localparam int C_RM    [NI] = '{0, 0, 0, 1};
    localparam int C_WM    [NI] = '{0, 1, 2, 0};

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce;
    logic        oce;
    logic        wre;
    logic [3:0]  be;
    logic [10:0] ad;
    logic [31:0] din;

    logic [7:0]    d0;
    logic [31:0]   d1;
    logic [11:0]   d2;
    logic [15:0]   d3;
    logic [NI-1:0] act_v;
    logic [NI-1:0] act_p;
    logic [31:0]   act_d [NI];

    always #5 clk = ~clk;

    sp_ram_be #(.DATA_WIDTH(8), .DEPTH(2048), .ADDR_WIDTH(11), .READ_MODE(0), .WRITE_MODE(0)) u0 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .oce(oce), .wre(wre), .be(be[0:0]), .ad(ad),
        .din(din[7:0]), .dout(d0), .dout_vld(act_v[0]), .parity_err(act_p[0]));
    sp_ram_be #(.DATA_WIDTH(32), .DEPTH(2048), .ADDR_WIDTH(11), .READ_MODE(0), .WRITE_MODE(1)) u1 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .oce(oce), .wre(wre), .be(be[3:0]), .ad(ad),
        .din(din[31:0]), .dout(d1), .dout_vld(act_v[1]), .parity_err(act_p[1]));
    sp_ram_be #(.DATA_WIDTH(12), .DEPTH(1000), .ADDR_WIDTH(11), .READ_MODE(0), .WRITE_MODE(2)) u2 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .oce(oce), .wre(wre), .be(be[1:0]), .ad(ad),
        .din(din[11:0]), .dout(d2), .dout_vld(act_v[2]), .parity_err(act_p[2]));
    sp_ram_be #(.DATA_WIDTH(16), .DEPTH(2048), .ADDR_WIDTH(11), .READ_MODE(1), .WRITE_MODE(0)) u3 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .oce(oce), .wre(wre), .be(be[1:0]), .ad(ad),
        .din(din[15:0]), .dout(d3), .dout_vld(act_v[3]), .parity_err(act_p[3]));

    assign act_d[0] = {24'h0, d0};
    assign act_d[1] = d1;
    assign act_d[2] = {20'h0, d2};
    assign act_d[3] = {16'h0, d3};

    // Word-level model: memory contents, a "contents known" flag, and the value each output should show.
    bit [31:0] mm [NI][2048];
    bit        kn [NI][2048];
    bit [31:0] e_s1 [NI];
    bit [31:0] e_s2 [NI];
    bit        e_v1 [NI];
    bit        e_v2 [NI];
    bit        e_p1 [NI];
    bit        e_p2 [NI];
    bit        e_k1 [NI];
    bit        e_k2 [NI];
    bit        corrupt9;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NI; i++) begin
                e_s1[i] = 32'h0; e_v1[i] = 1'b0; e_p1[i] = 1'b0; e_k1[i] = 1'b1;
                e_s2[i] = 32'h0; e_v2[i] = 1'b0; e_p2[i] = 1'b0; e_k2[i] = 1'b1;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                bit [31:0] dmask;
                bit [31:0] m;
                bit [31:0] old;
                bit [31:0] nw;
                bit        inr;
                bit        okn;
                bit        pe;
                bit        full;
                int        a;
                dmask = 32'((64'd1 << C_DW[i]) - 64'd1);
                a = int'(ad);
                if (C_RM[i] == 1) begin
                    if (oce) begin
                        e_s2[i] = e_s1[i]; e_v2[i] = e_v1[i]; e_p2[i] = e_p1[i]; e_k2[i] = e_k1[i];
                    end else begin
                        e_v2[i] = 1'b0; e_p2[i] = 1'b0;
                    end
                end
                e_v1[i] = 1'b0;
                e_p1[i] = 1'b0;
                if (ce) begin
                    inr = (a < C_DEPTH[i]);
                    old = inr ? mm[i][a] : 32'h0;
                    okn = inr ? kn[i][a] : 1'b1;
                    pe  = inr && (i == 0) && (a == 9) && corrupt9;
                    m = 32'h0;
                    for (int j = 0; j < 4; j++)
                        if (be[j] && (8 * j < C_DW[i])) m = m | (32'hFF << (8 * j));
                    m = m & dmask;
                    full = (m == dmask);
                    nw = ((old & ~m) | (din & m)) & dmask;
                    if (!wre) begin
                        e_s1[i] = old; e_v1[i] = 1'b1; e_p1[i] = pe; e_k1[i] = okn;
                    end else begin
                        if (C_WM[i] == 1) begin
                            e_s1[i] = nw; e_v1[i] = 1'b1; e_k1[i] = okn || full;
                        end else if (C_WM[i] == 2) begin
                            e_s1[i] = old; e_v1[i] = 1'b1; e_p1[i] = pe; e_k1[i] = okn;
                        end
                        if (inr) begin
                            mm[i][a] = nw;
                            kn[i][a] = okn || full;
                        end
                    end
                end
            end
        end
    end

    // Hand-computed expectations, each tied to a negedge index.
    int        pin_cyc  [64];
    int        pin_inst [64];
    bit [31:0] pin_d    [64];
    bit        pin_v    [64];
    bit        pin_p    [64];
    int        npin = 0;

    int cc   = 0;
    int nvec = 0;
    int nerr = 0;

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            bit [31:0] ed;
            bit        ev;
            bit        ep;
            bit        ek;
            ed = (C_RM[i] == 1) ? e_s2[i] : e_s1[i];
            ev = (C_RM[i] == 1) ? e_v2[i] : e_v1[i];
            ep = (C_RM[i] == 1) ? e_p2[i] : e_p1[i];
            ek = (C_RM[i] == 1) ? e_k2[i] : e_k1[i];
            nvec++;
            if (act_v[i] !== ev) begin
                nerr++;
                $display("FAIL vld u%0d cyc %0d: got %b want %b", i, cc, act_v[i], ev);
            end
            if (ek) begin
                nvec++;
                if (act_d[i] !== ed) begin
                    nerr++;
                    $display("FAIL data u%0d cyc %0d: got %h want %h", i, cc, act_d[i], ed);
                end
                nvec++;
                if (act_p[i] !== ep) begin
                    nerr++;
                    $display("FAIL perr u%0d cyc %0d: got %b want %b", i, cc, act_p[i], ep);
                end
            end
        end
        for (int p = 0; p < npin; p++) begin
            if (pin_cyc[p] == cc) begin
                int k;
                k = pin_inst[p];
                nvec++;
                if (act_d[k] !== pin_d[p] || act_v[k] !== pin_v[p] || act_p[k] !== pin_p[p]) begin
                    nerr++;
                    $display("FAIL pin%0d u%0d cyc %0d: got d=%h v=%b p=%b want d=%h v=%b p=%b",
                             p, k, cc, act_d[k], act_v[k], act_p[k], pin_d[p], pin_v[p], pin_p[p]);
                end
            end
        end
        cc++;
    end

    task automatic acc(input bit c, input bit w, input bit [3:0] b, input int a,
                       input bit [31:0] d, input bit o);
        ce  = c;
        wre = w;
        be  = b;
        ad  = 11'(a);
        din = d;
        oce = o;
        $display("cyc %0d: ce=%b wre=%b be=%h ad=%h din=%h oce=%b", cc, c, w, b, a, d, o);
        @(negedge clk);
        #1;
    endtask

    task automatic pin(input int inst, input int ahead, input bit [31:0] d, input bit v, input bit p);
        pin_cyc[npin]  = cc + ahead;
        pin_inst[npin] = inst;
        pin_d[npin]    = d;
        pin_v[npin]    = v;
        pin_p[npin]    = p;
        npin++;
    endtask

    initial begin
        corrupt9 = 1'b0;
        reset_n = 1'b0;
        ce = 1'b0; oce = 1'b1; wre = 1'b0; be = 4'h0; ad = 11'h0; din = 32'h0;
        pin(0, 0, 32'h0, 1'b0, 1'b0);
        pin(3, 0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        acc(0, 0, 4'h0, 0, 32'h0, 1);
        reset_n = 1'b1;

        // Asynchronous reset while dout shows 0xA5, then read back a word written before it.
        acc(1, 1, 4'hF, 'h7FF, 32'h3C, 1);
        acc(1, 1, 4'hF, 'h010, 32'hA5, 1);
        pin(0, 0, 32'hA5, 1'b1, 1'b0);
        acc(1, 0, 4'h0, 'h010, 32'h0, 1);
        ce = 1'b0;
        pin(0, 0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        acc(0, 0, 4'h0, 0, 32'h0, 1);
        reset_n = 1'b1;
        pin(0, 0, 32'h3C, 1'b1, 1'b0);
        acc(1, 0, 4'h0, 'h7FF, 32'h0, 1);
        pin(0, 0, 32'h3C, 1'b0, 1'b0);
        acc(0, 0, 4'h0, 0, 32'h0, 1);

        // Byte-enable merge on the 32-bit instance.
        acc(1, 1, 4'hF, 5, 32'h11223344, 1);
        pin(1, 0, 32'h11BB33DD, 1'b1, 1'b0);
        acc(1, 1, 4'b0101, 5, 32'hAABBCCDD, 1);
        pin(1, 0, 32'h11BB33DD, 1'b1, 1'b0);
        pin(3, 1, 32'h000033DD, 1'b1, 1'b0);
        acc(1, 0, 4'h0, 5, 32'h0, 1);
        acc(0, 0, 4'h0, 0, 32'h0, 1);

        // Write-collision modes on addr 3.
        acc(1, 1, 4'hF, 3, 32'h5A, 1);
        pin(0, 0, 32'h5A, 1'b1, 1'b0);
        acc(1, 0, 4'h0, 3, 32'h0, 1);
        pin(0, 0, 32'h5A, 1'b0, 1'b0);
        pin(1, 0, 32'hC3, 1'b1, 1'b0);
        pin(2, 0, 32'h05A, 1'b1, 1'b0);
        acc(1, 1, 4'hF, 3, 32'hC3, 1);
        pin(0, 0, 32'hC3, 1'b1, 1'b0);
        pin(1, 0, 32'hC3, 1'b1, 1'b0);
        pin(2, 0, 32'h0C3, 1'b1, 1'b0);
        pin(3, 1, 32'h00C3, 1'b1, 1'b0);
        acc(1, 0, 4'h0, 3, 32'h0, 1);
        acc(0, 0, 4'h0, 0, 32'h0, 1);

        // Pipelined output register with oce.
        acc(1, 1, 4'hF, 1, 32'h1111, 1);
        acc(1, 1, 4'hF, 2, 32'h2222, 1);
        pin(3, 1, 32'h1111, 1'b1, 1'b0);
        acc(1, 0, 4'h0, 1, 32'h0, 1);
        pin(3, 1, 32'h2222, 1'b1, 1'b0);
        acc(1, 0, 4'h0, 2, 32'h0, 1);
        acc(0, 0, 4'h0, 0, 32'h0, 1);
        acc(0, 0, 4'h0, 0, 32'h0, 1);
        acc(1, 0, 4'h0, 1, 32'h0, 0);
        pin(3, 0, 32'h1111, 1'b1, 1'b0);
        acc(1, 0, 4'h0, 2, 32'h0, 1);
        pin(3, 0, 32'h1111, 1'b0, 1'b0);
        acc(0, 0, 4'h0, 0, 32'h0, 0);
        acc(0, 0, 4'h0, 0, 32'h0, 1);

        // Out-of-range address on the 1000-word instance.
        acc(1, 1, 4'hF, 999, 32'h123, 1);
        pin(2, 0, 32'h0, 1'b1, 1'b0);
        acc(1, 1, 4'hF, 1000, 32'hFF, 1);
        pin(2, 0, 32'h0, 1'b1, 1'b0);
        acc(1, 0, 4'h0, 1000, 32'h0, 1);
        pin(2, 0, 32'h123, 1'b1, 1'b0);
        acc(1, 0, 4'h0, 999, 32'h0, 1);

        // Table sweep: full writes, every byte-enable pattern, reads with oce toggling.
        for (int k = 0; k < 16; k++) acc(1, 1, 4'hF, 32 + k, 32'hA5A55A5A ^ (k * 32'h01010101), 1);
        for (int k = 0; k < 16; k++) acc(1, 1, 4'(k), 32 + k, ~(k * 32'h0F0F0F0F), 1);
        for (int k = 0; k < 16; k++) acc(1, 0, 4'h0, 32 + k, 32'h0, k[0]);
        acc(0, 0, 4'h0, 0, 32'h0, 1);

`ifdef SP_RAM_BE_PARITY_EN
        acc(1, 1, 4'hF, 8, 32'h77, 1);
        acc(1, 1, 4'hF, 9, 32'h77, 1);
        u0.g_lane[0].par_mem[9] = ~u0.g_lane[0].par_mem[9];
        corrupt9 = 1'b1;
        pin(0, 0, 32'h77, 1'b1, 1'b1);
        acc(1, 0, 4'h0, 9, 32'h0, 1);
        pin(0, 0, 32'h77, 1'b1, 1'b0);
        acc(1, 0, 4'h0, 8, 32'h0, 1);
`endif

        acc(0, 0, 4'h0, 0, 32'h0, 1);
        acc(0, 0, 4'h0, 0, 32'h0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
